seqdet_sched: RTL

Round-robin scheduler that shares one serial sequence detector (`seqdet`) among `NREQ` requesters. It accepts a parallel word from the granted requester and clears the detector. It then serializes the word into the detector one bit per clock and counts the cycles in which the detector reports a match. Finally it returns the count, tagged with the requester index. It sits between the requester-side logic and the single `seqdet` instance.

---
 rtl/seqdet_sched.sv | 99 +++++++++
 1 files changed

// File: rtl/seqdet_sched.sv
// seqdet_sched: round-robin scheduler sharing one serial sequence detector among NREQ requesters.
// Define SEQDET_SCHED_LSB_FIRST_EN to serialize words LSB first (default MSB first).
module seqdet_sched #(
  parameter int NREQ    = 4,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     det_reset,
  output logic                     det_in,
  input  logic                     det_out,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [CNT_W-1:0]         rsp_count,
  input  logic                     rsp_ready,
  output logic                     busy
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CYC_W = $clog2(WORD_W + DET_LAT + 1);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, SHIFT = 3'd2, DRAIN = 3'd3, RESP = 3'd4;
  localparam logic [CYC_W-1:0] LAST_BIT = CYC_W'(WORD_W - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WORD_W + DET_LAT - 1);
  localparam logic [CYC_W-1:0] WIN      = CYC_W'(DET_LAT);
  logic [2:0]        state;
  logic [ID_W-1:0]   last_id, gid;
  logic              found, grant, more, in_win, nbit;
  logic [WORD_W-1:0] sr, sr_nx;
  logic [CYC_W-1:0]  cyc;
  // Scan from farthest to nearest so the first valid index after last_id wins.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_id) + k) % NREQ]) begin
        found = 1'b1;
        gid   = ID_W'((int'(last_id) + k) % NREQ);
      end
    end
  end
`ifdef SEQDET_SCHED_LSB_FIRST_EN
  assign nbit  = sr[0];
  assign sr_nx = sr >> 1;
`else
  assign nbit  = sr[WORD_W-1];
  assign sr_nx = sr << 1;
`endif
  assign grant     = state == IDLE && found;
  assign req_ready = (grant && reset) ? NREQ'(1) << gid : '0;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  // det_in is registered, so the next bit is loaded one cycle ahead of its SHIFT slot.
  assign more   = state == CLEAR || (state == SHIFT && cyc != LAST_BIT);
  assign in_win = (state == SHIFT || state == DRAIN) && cyc >= WIN;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_id   <= ID_W'(NREQ - 1);
      rsp_id    <= '0;
      rsp_count <= '0;
      sr        <= '0;
      cyc       <= '0;
      det_reset <= 1'b1;
      det_in    <= 1'b0;
    end else begin
      det_reset <= grant;
      det_in    <= more & nbit;
      if (more) sr <= sr_nx;
      if (in_win && det_out && rsp_count != '1) rsp_count <= rsp_count + 1'b1;
      case (state)
        IDLE: if (found) begin
          state   <= CLEAR;
          sr      <= req_data[gid*WORD_W +: WORD_W];
          rsp_id  <= gid;
          last_id <= gid;
        end
        CLEAR: begin
          state     <= SHIFT;
          cyc       <= '0;
          rsp_count <= '0;
        end
        SHIFT: begin
          cyc <= cyc + 1'b1;
          if (cyc == LAST_BIT) state <= (DET_LAT == 0) ? RESP : DRAIN;
        end
        DRAIN: begin
          cyc <= cyc + 1'b1;
          if (cyc == LAST_CYC) state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
